// File: rtl/seven_segment_scanner_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seven_segment_scanner_pkg : shared display timing constants and scan states
// Revision 1.0
// ----------------------------------------------------------------------------
package seven_segment_scanner_pkg;

   localparam int CLKS_PER_DIGIT_100MHZ = 100000;
   localparam int BLANK_CLKS_DEFAULT    = 1000;

   localparam int                    MAX_DIGITS = 16;
   localparam logic [MAX_DIGITS-1:0] ANODES_OFF = '1;

   typedef enum logic [0:0] {
      S_BLANK = 1'b0,
      S_ON    = 1'b1
   } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/seven_segment_scanner_slot_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seven_segment_scanner_slot_timer : per-digit slot counter with wrap and
// end-of-blanking strobes.  Revision 1.0
// ----------------------------------------------------------------------------
module seven_segment_scanner_slot_timer
   import seven_segment_scanner_pkg::*;
#(
   parameter int CLKS_PER_DIGIT = CLKS_PER_DIGIT_100MHZ,
   parameter int BLANK_CLKS     = BLANK_CLKS_DEFAULT
)(
   input  logic i_Clk,
   input  logic i_Rst_n,
   output logic o_Wrap,
   output logic o_Blank_Done
);

   localparam int CNT_W = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;

   logic [CNT_W-1:0] count_q, count_d;

   // Strobes are asserted in the last cycle before the event edge so that
   // registered consumers change state exactly on that edge.
   assign o_Wrap       = (count_q == CNT_W'(CLKS_PER_DIGIT - 1));
   assign o_Blank_Done = (count_q == CNT_W'(BLANK_CLKS - 1));

   always_comb begin
      count_d = count_q + CNT_W'(1);
      if (o_Wrap) begin
         count_d = '0;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seven_segment_scanner : time-multiplexed common-anode hex display scanner
// with slot blanking, leading-zero suppression and tear-free loads. Rev 1.0
// ----------------------------------------------------------------------------
module seven_segment_scanner
   import seven_segment_scanner_pkg::*;
#(
   parameter  int NUM_DIGITS     = 4,
   parameter  int CLKS_PER_DIGIT = CLKS_PER_DIGIT_100MHZ,
   parameter  int BLANK_CLKS     = BLANK_CLKS_DEFAULT,
   parameter  int LZ_SUPPRESS    = 1,
   localparam int IDX_W          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
   localparam int VAL_W          = 4 * NUM_DIGITS
)(
   input  logic             i_Clk,
   input  logic             i_Rst_n,
   input  logic             i_Enable,
   input  logic             i_Load,
   input  logic [VAL_W-1:0] i_Value,
   output logic [3:0]       o_Nibble,
   output logic [IDX_W-1:0] o_Digit_Idx,
   output logic [NUM_DIGITS-1:0] o_Anode,
   output logic             o_Frame_Start
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   scan_state_t           state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [3:0]            nibble_q, nibble_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;
   logic                  frame_start_q, frame_start_d;
   logic [VAL_W-1:0]      pending_q, pending_d;
   logic [VAL_W-1:0]      display_q, display_d;
   logic                  pending_flag_q, pending_flag_d;

   logic                  w_slot_wrap;
   logic                  w_blank_done;
   logic                  w_frame_wrap;
   logic [3:0]            w_digit_sel;
   logic                  w_upper_zero;
   logic                  w_lz_blank;
   logic [NUM_DIGITS-1:0] w_one_cold;

   seven_segment_scanner_slot_timer #(
      .CLKS_PER_DIGIT (CLKS_PER_DIGIT),
      .BLANK_CLKS     (BLANK_CLKS)
   ) u_slot_timer (
      .i_Clk        (i_Clk),
      .i_Rst_n      (i_Rst_n),
      .o_Wrap       (w_slot_wrap),
      .o_Blank_Done (w_blank_done)
   );

   assign w_frame_wrap = w_slot_wrap && (idx_q == LAST_IDX);

   always_comb begin
      idx_d = idx_q;
      if (w_slot_wrap) begin
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_BLANK: if (w_blank_done) state_d = S_ON;
         S_ON:    if (w_slot_wrap)  state_d = S_BLANK;
         default: state_d = S_BLANK;
      endcase
   end

   // Display only changes on the frame boundary; a load landing on that very
   // edge bypasses the pending register so it is not deferred a whole frame.
   always_comb begin
      pending_d      = pending_q;
      pending_flag_d = pending_flag_q;
      display_d      = display_q;
      if (w_frame_wrap) begin
         pending_flag_d = 1'b0;
         if (i_Load) begin
            display_d = i_Value;
         end else if (pending_flag_q) begin
            display_d = pending_q;
         end
      end else if (i_Load) begin
         pending_d      = i_Value;
         pending_flag_d = 1'b1;
      end
   end

   always_comb begin
      w_digit_sel  = 4'h0;
      w_upper_zero = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (IDX_W'(k) == idx_d) begin
            w_digit_sel = display_d[4*k +: 4];
         end
         if ((IDX_W'(k) >= idx_d) && (display_d[4*k +: 4] != 4'h0)) begin
            w_upper_zero = 1'b0;
         end
      end
      w_lz_blank = (LZ_SUPPRESS != 0) && (idx_d != '0) && w_upper_zero;
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_one_cold
      assign w_one_cold[g] = (idx_d != IDX_W'(g));
   end

   // All outputs are computed from next-state values so that they line up
   // with the registered state in the same cycle.
   always_comb begin
      nibble_d = nibble_q;
      if (w_slot_wrap) begin
         nibble_d = w_digit_sel;
      end
      anode_d = ANODES_OFF[NUM_DIGITS-1:0];
      if ((state_d == S_ON) && i_Enable && !w_lz_blank) begin
         anode_d = w_one_cold;
      end
      frame_start_d = w_frame_wrap;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q        <= S_BLANK;
         idx_q          <= '0;
         nibble_q       <= 4'h0;
         anode_q        <= ANODES_OFF[NUM_DIGITS-1:0];
         frame_start_q  <= 1'b0;
         pending_q      <= '0;
         display_q      <= '0;
         pending_flag_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         nibble_q       <= nibble_d;
         anode_q        <= anode_d;
         frame_start_q  <= frame_start_d;
         pending_q      <= pending_d;
         display_q      <= display_d;
         pending_flag_q <= pending_flag_d;
      end
   end

   assign o_Nibble      = nibble_q;
   assign o_Digit_Idx   = idx_q;
   assign o_Anode       = anode_q;
   assign o_Frame_Start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seven_segment_scanner : directed bench with a cycle-time display model.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_seven_segment_scanner;

   localparam int N     = 4;
   localparam int CPD   = 8;
   localparam int BLK   = 2;
   localparam int FRAME = N * CPD;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        en    = 1'b1;
   logic        load  = 1'b0;
   logic [15:0] value = 16'h0000;

   logic [3:0] nib0, nib1, an0, an1;
   logic [1:0] idx0, idx1;
   logic       fs0, fs1;

   int checks   = 0;
   int failures = 0;

   // Model: t = cycles since reset release, shown = value of the current frame
   int          t         = 0;
   logic [15:0] shown     = 16'h0000;
   logic [15:0] last_load = 16'h0000;
   bit          have_load = 1'b0;
   bit          en_q      = 1'b1;

   always #5 clk = ~clk;

   seven_segment_scanner #(
      .NUM_DIGITS (N), .CLKS_PER_DIGIT (CPD), .BLANK_CLKS (BLK), .LZ_SUPPRESS (0)
   ) u_dut_std (
      .i_Clk (clk), .i_Rst_n (rst_n), .i_Enable (en), .i_Load (load), .i_Value (value),
      .o_Nibble (nib0), .o_Digit_Idx (idx0), .o_Anode (an0), .o_Frame_Start (fs0)
   );

   seven_segment_scanner #(
      .NUM_DIGITS (N), .CLKS_PER_DIGIT (CPD), .BLANK_CLKS (BLK), .LZ_SUPPRESS (1)
   ) u_dut_lz (
      .i_Clk (clk), .i_Rst_n (rst_n), .i_Enable (en), .i_Load (load), .i_Value (value),
      .o_Nibble (nib1), .o_Digit_Idx (idx1), .o_Anode (an1), .o_Frame_Start (fs1)
   );

   always @(posedge clk or negedge rst_n) begin : model
      int          tn;
      logic [15:0] latest;
      bit          any;
      if (!rst_n) begin
         t         <= 0;
         shown     <= 16'h0000;
         have_load <= 1'b0;
         en_q      <= 1'b1;
      end else begin
         tn     = t + 1;
         latest = load ? value : last_load;
         any    = load || have_load;
         en_q   <= en;
         t      <= tn;
         if (tn % FRAME == 0) begin
            if (any) shown <= latest;
            have_load <= 1'b0;
         end else begin
            last_load <= latest;
            have_load <= any;
         end
      end
   end

   function automatic int exp_idx();
      return (t / CPD) % N;
   endfunction

   function automatic logic [3:0] exp_nibble();
      logic [15:0] s;
      s = shown >> (4 * exp_idx());
      return s[3:0];
   endfunction

   function automatic logic [3:0] exp_anode(input bit lz);
      logic [3:0] a;
      bit         lit;
      int         idx;
      idx = exp_idx();
      a   = 4'hF;
      lit = ((t % CPD) >= BLK) && en_q;
      if (lz && idx > 0 && (shown >> (4 * idx)) == 16'h0000) lit = 1'b0;
      if (lit) a[idx] = 1'b0;
      return a;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
      end
   endtask

   always @(negedge clk) begin
      check("idx_std",    idx0, exp_idx());
      check("idx_lz",     idx1, exp_idx());
      check("nibble_std", nib0, exp_nibble());
      check("nibble_lz",  nib1, exp_nibble());
      check("anode_std",  an0,  exp_anode(1'b0));
      check("anode_lz",   an1,  exp_anode(1'b1));
      check("fs_std",     fs0,  (t > 0 && t % FRAME == 0));
      check("fs_lz",      fs1,  (t > 0 && t % FRAME == 0));
   end

   task automatic wait_t(input int target);
      int n;
      n = 0;
      while (t != target && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("wait_t", t, target);
   endtask

   task automatic do_load(input logic [15:0] v);
      load  = 1'b1;
      value = v;
      @(negedge clk);
      load  = 1'b0;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_anode",  an0,  4'b1111);
      check("rst_nibble", nib0, 4'h0);
      check("rst_idx",    idx0, 2'd0);
      check("rst_fs",     fs0,  1'b0);
      #2 rst_n = 1'b1;

      wait_t(2);   do_load(16'h1234);
      wait_t(32);  check("f1_fs", fs0, 1'b1); check("f1_nib_d0", nib0, 4'h4);
      wait_t(34);  check("f1_an_d0", an0, 4'b1110); check("f1_an_d0_lz", an1, 4'b1110);
      wait_t(61);  check("f1_an_d3", an0, 4'b0111); check("f1_nib_d3", nib0, 4'h1);
      wait_t(64);  check("f2_fs", fs0, 1'b1);

      wait_t(66);  do_load(16'h0005);
      wait_t(99);  check("lz5_an_d0", an1, 4'b1110); check("lz5_nib_d0", nib1, 4'h5);
      wait_t(107); check("lz5_an_d1", an1, 4'b1111); check("std5_an_d1", an0, 4'b1101);

      wait_t(130); do_load(16'h0000);
      wait_t(163); check("lz0_an_d0", an1, 4'b1110); check("lz0_nib_d0", nib1, 4'h0);
      wait_t(188); check("lz0_an_d3", an1, 4'b1111); check("std0_an_d3", an0, 4'b0111);

      wait_t(209); do_load(16'hAAAA);
      wait_t(217); do_load(16'hBBBB);
      wait_t(220); check("tear_nib_cur", nib0, 4'h0);
      wait_t(234); check("tear_nib_next", nib0, 4'hB); check("tear_an_next", an0, 4'b1101);

      wait_t(255); do_load(16'hC0DE);
      wait_t(258); check("bnd_nib_d0", nib0, 4'hE); check("bnd_an_d0", an0, 4'b1110);

      wait_t(262); check("en_before", an0, 4'b1110);
      en = 1'b0;
      wait_t(263); check("en_off", an0, 4'b1111);
      wait_t(270); check("en_idx_adv", idx0, 2'd1);
      wait_t(282); check("en_off_on", an0, 4'b1111);
      en = 1'b1;
      wait_t(283); check("en_resume", an0, 4'b0111); check("en_nib", nib0, 4'hC);

      wait_t(308); check("pre_rst_an", an0, 4'b1011);
      #2 rst_n = 1'b0;
      #1;
      check("arst_anode",  an0,  4'b1111);
      check("arst_nibble", nib0, 4'h0);
      check("arst_idx",    idx0, 2'd0);
      check("arst_fs",     fs0,  1'b0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      wait_t(34);  check("post_nib_d0", nib0, 4'h0); check("post_an_d0", an0, 4'b1110);
      wait_t(42);  check("post_an_d1", an0, 4'b1101); check("post_an_d1_lz", an1, 4'b1111);

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
